// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and constants for the data cache
//
// Purpose: bus command encoding, line geometry and address-split constants
//          shared by dcache and dcache_mem.
// Ports:   none (package).
package dcache_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_command_t;

  localparam int DCACHE_BLOCK_SIZE = 64;
  localparam int DCACHE_LINES      = 32;
  localparam int NUM_MEM_TAGS      = 16;

  localparam int ADDR_W    = 64;
  localparam int IDX_W     = $clog2(DCACHE_LINES);
  localparam int IDX_LSB   = 3;
  localparam int TAG_LSB   = IDX_LSB + IDX_W;
  localparam int TAG_W     = ADDR_W - TAG_LSB;
  localparam int MEM_TAG_W = $clog2(NUM_MEM_TAGS);

  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[TAG_LSB-1:IDX_LSB];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:TAG_LSB];
  endfunction

endpackage

// File: rtl/dcache_mem.sv
// rtl/dcache_mem.sv - direct-mapped line array for the data cache
//
// Purpose: per-line valid/tag/data storage with one combinational read port
//          and one synchronous write port. Only the valid bits are reset.
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   rd_idx            line index to read
//   rd_valid/tag/data contents of line rd_idx (combinational)
//   wr_en             write line wr_idx at the clock edge (sets valid)
//   wr_idx/tag/data   write address and contents
module dcache_mem
  import dcache_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset,
  input  logic [IDX_W-1:0]             rd_idx,
  output logic                         rd_valid,
  output logic [TAG_W-1:0]             rd_tag,
  output logic [DCACHE_BLOCK_SIZE-1:0] rd_data,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [TAG_W-1:0]             wr_tag,
  input  logic [DCACHE_BLOCK_SIZE-1:0] wr_data
);

  logic [DCACHE_LINES-1:0]      valid;
  logic [TAG_W-1:0]             tags  [DCACHE_LINES];
  logic [DCACHE_BLOCK_SIZE-1:0] lines [DCACHE_LINES];

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = lines[rd_idx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless while valid is clear, so they
  // carry no reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tags[wr_idx]  <= wr_tag;
      lines[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/dcache.sv
// rtl/dcache.sv - non-blocking direct-mapped write-through data cache
//
// Purpose: serves LSQ loads from a direct-mapped array, forwards misses and
//          all stores to a tagged memory bus, and tracks outstanding misses
//          in a table indexed by memory tag so fills land in the right line.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   Dmem2proc_response    tag memory gives this cycle's request (0 = rejected)
//   Dmem2proc_tag/data    completing memory transaction (tag 0 = none)
//   proc2Dcache_addr/command/data   processor request
//   proc2Dmem_command/addr/data     request to memory
//   Dcache2proc_data      hit data, or fill data when Dcache2proc_tag != 0
//   Dcache2proc_tag       tag of a miss completing this cycle
//   Dcache2proc_response  memory tag assigned to this cycle's miss or store
//   Dcache_data_hit       current load hits
module dcache
  import dcache_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset,
  input  logic [MEM_TAG_W-1:0]         Dmem2proc_response,
  input  logic [MEM_TAG_W-1:0]         Dmem2proc_tag,
  input  logic [DCACHE_BLOCK_SIZE-1:0] Dmem2proc_data,
  input  logic [ADDR_W-1:0]            proc2Dcache_addr,
  input  bus_command_t                 proc2Dcache_command,
  input  logic [DCACHE_BLOCK_SIZE-1:0] proc2Dcache_data,
  output bus_command_t                 proc2Dmem_command,
  output logic [ADDR_W-1:0]            proc2Dmem_addr,
  output logic [DCACHE_BLOCK_SIZE-1:0] proc2Dmem_data,
  output logic [DCACHE_BLOCK_SIZE-1:0] Dcache2proc_data,
  output logic [MEM_TAG_W-1:0]         Dcache2proc_tag,
  output logic [MEM_TAG_W-1:0]         Dcache2proc_response,
  output logic                         Dcache_data_hit
);

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             unused_offset;

  assign req_idx       = addr_index(proc2Dcache_addr);
  assign req_tag       = addr_tag(proc2Dcache_addr);
  assign unused_offset = ^proc2Dcache_addr[IDX_LSB-1:0];

  // Line array
  logic                         rd_valid;
  logic [TAG_W-1:0]             rd_tag;
  logic [DCACHE_BLOCK_SIZE-1:0] rd_data;
  logic                         wr_en;
  logic [IDX_W-1:0]             wr_idx;
  logic [TAG_W-1:0]             wr_tag;
  logic [DCACHE_BLOCK_SIZE-1:0] wr_data;

  dcache_mem u_mem (
    .clock    (clock),
    .reset    (reset),
    .rd_idx   (req_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_tag   (wr_tag),
    .wr_data  (wr_data)
  );

  // Miss table, indexed by memory tag. Entry 0 is never written because
  // tag 0 means "none" on both memory-side buses.
  logic [NUM_MEM_TAGS-1:0] mt_valid;
  logic [IDX_W-1:0]        mt_idx [NUM_MEM_TAGS];
  logic [TAG_W-1:0]        mt_tag [NUM_MEM_TAGS];

  logic is_load, is_store, fill_active, line_hit;
  logic load_hit, load_miss, store_hit, issue;
  logic record_miss, store_wr, fill_wr, fill_blocked;
  logic [NUM_MEM_TAGS-1:0] store_kill;

  always_comb begin
    is_load     = (proc2Dcache_command == BUS_LOAD);
    is_store    = (proc2Dcache_command == BUS_STORE);
    fill_active = (Dmem2proc_tag != '0);
    line_hit    = rd_valid && (rd_tag == req_tag);

    // A fill owns the return data bus, so a load that would hit this cycle
    // is pushed to memory instead.
    load_hit    = is_load && line_hit && !fill_active;
    load_miss   = is_load && !load_hit;
    store_hit   = is_store && line_hit;
    issue       = load_miss || is_store;
    record_miss = load_miss && (Dmem2proc_response != '0);
    store_wr    = store_hit && (Dmem2proc_response != '0);

    // A store supersedes any outstanding load to the same block; its fill
    // would otherwise install pre-store data.
    for (int i = 0; i < NUM_MEM_TAGS; i++) begin
      store_kill[i] = is_store && mt_valid[i] &&
                      (mt_idx[i] == req_idx) && (mt_tag[i] == req_tag);
    end

    // The same protection for a fill of that block landing this very cycle.
    fill_blocked = is_store &&
                   (mt_idx[Dmem2proc_tag] == req_idx) &&
                   (mt_tag[Dmem2proc_tag] == req_tag);
    fill_wr      = fill_active && mt_valid[Dmem2proc_tag] && !fill_blocked;

    // One write port: the store wins. Dropping a fill only costs a later
    // miss, whereas dropping a store update would leave stale data.
    wr_en   = store_wr || fill_wr;
    wr_idx  = req_idx;
    wr_tag  = req_tag;
    wr_data = proc2Dcache_data;
    if (!store_wr) begin
      wr_idx  = mt_idx[Dmem2proc_tag];
      wr_tag  = mt_tag[Dmem2proc_tag];
      wr_data = Dmem2proc_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mt_valid <= '0;
    end else begin
      if (fill_active) begin
        mt_valid[Dmem2proc_tag] <= 1'b0;
      end
      mt_valid <= (fill_active ? (mt_valid & ~(NUM_MEM_TAGS'(1) << Dmem2proc_tag))
                               : mt_valid) & ~store_kill;
      // Ordered last so a new miss reusing the completing tag survives.
      if (record_miss) begin
        mt_valid[Dmem2proc_response] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (record_miss) begin
      mt_idx[Dmem2proc_response] <= req_idx;
      mt_tag[Dmem2proc_response] <= req_tag;
    end
  end

  // Outputs are held at their idle values while reset is asserted.
  always_comb begin
    proc2Dmem_command    = BUS_NONE;
    proc2Dmem_addr       = '0;
    proc2Dmem_data       = '0;
    Dcache2proc_data     = '0;
    Dcache2proc_tag      = '0;
    Dcache2proc_response = '0;
    Dcache_data_hit      = 1'b0;
    if (!reset) begin
      if (issue) begin
        proc2Dmem_command    = is_store ? BUS_STORE : BUS_LOAD;
        proc2Dmem_addr       = {proc2Dcache_addr[ADDR_W-1:IDX_LSB], {IDX_LSB{1'b0}}};
        Dcache2proc_response = Dmem2proc_response;
      end
      if (is_store) begin
        proc2Dmem_data = proc2Dcache_data;
      end
      if (fill_active) begin
        Dcache2proc_tag  = Dmem2proc_tag;
        Dcache2proc_data = Dmem2proc_data;
      end else if (load_hit) begin
        Dcache2proc_data = rd_data;
      end
      Dcache_data_hit = load_hit;
    end
  end

endmodule

// File: tb/tb_dcache.sv
// tb/tb_dcache.sv - directed self-checking bench for dcache
module tb_dcache;
  import dcache_pkg::*;

  logic                         clock = 1'b0;
  logic                         reset;
  logic [MEM_TAG_W-1:0]         Dmem2proc_response;
  logic [MEM_TAG_W-1:0]         Dmem2proc_tag;
  logic [DCACHE_BLOCK_SIZE-1:0] Dmem2proc_data;
  logic [ADDR_W-1:0]            proc2Dcache_addr;
  bus_command_t                 proc2Dcache_command;
  logic [DCACHE_BLOCK_SIZE-1:0] proc2Dcache_data;
  bus_command_t                 proc2Dmem_command;
  logic [ADDR_W-1:0]            proc2Dmem_addr;
  logic [DCACHE_BLOCK_SIZE-1:0] proc2Dmem_data;
  logic [DCACHE_BLOCK_SIZE-1:0] Dcache2proc_data;
  logic [MEM_TAG_W-1:0]         Dcache2proc_tag;
  logic [MEM_TAG_W-1:0]         Dcache2proc_response;
  logic                         Dcache_data_hit;

  int total = 0;
  int bad   = 0;

  dcache dut (
    .clock                (clock),
    .reset                (reset),
    .Dmem2proc_response   (Dmem2proc_response),
    .Dmem2proc_tag        (Dmem2proc_tag),
    .Dmem2proc_data       (Dmem2proc_data),
    .proc2Dcache_addr     (proc2Dcache_addr),
    .proc2Dcache_command  (proc2Dcache_command),
    .proc2Dcache_data     (proc2Dcache_data),
    .proc2Dmem_command    (proc2Dmem_command),
    .proc2Dmem_addr       (proc2Dmem_addr),
    .proc2Dmem_data       (proc2Dmem_data),
    .Dcache2proc_data     (Dcache2proc_data),
    .Dcache2proc_tag      (Dcache2proc_tag),
    .Dcache2proc_response (Dcache2proc_response),
    .Dcache_data_hit      (Dcache_data_hit)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read 2 units later.
  task automatic drive(input bus_command_t cmd, input logic [63:0] addr,
                       input logic [63:0] sdata, input logic [3:0] resp,
                       input logic [3:0] mtag, input logic [63:0] mdata);
    proc2Dcache_command = cmd;
    proc2Dcache_addr    = addr;
    proc2Dcache_data    = sdata;
    Dmem2proc_response  = resp;
    Dmem2proc_tag       = mtag;
    Dmem2proc_data      = mdata;
    #2;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string name, input bus_command_t cmd,
                            input logic [63:0] maddr, input logic [63:0] mdata,
                            input logic [3:0] resp, input logic hit,
                            input logic [3:0] tag, input logic [63:0] data);
    chk({name, ".cmd"},  64'(proc2Dmem_command),    64'(cmd));
    chk({name, ".addr"}, proc2Dmem_addr,            maddr);
    chk({name, ".wdat"}, proc2Dmem_data,            mdata);
    chk({name, ".resp"}, 64'(Dcache2proc_response), 64'(resp));
    chk({name, ".hit"},  64'(Dcache_data_hit),      64'(hit));
    chk({name, ".tag"},  64'(Dcache2proc_tag),      64'(tag));
    chk({name, ".data"}, Dcache2proc_data,          data);
  endtask

  initial begin
    reset = 1'b1;
    #1;
    drive(BUS_LOAD, 64'h1230, 64'h0, 4'd1, 4'd2, 64'h77);
    expect_out("in_reset", BUS_NONE, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;

    // Cold miss, recorded under memory tag 1 (line 6, tag 0x12).
    drive(BUS_LOAD, 64'h1230, 64'h0, 4'd1, 4'd0, 64'h0);
    expect_out("miss1", BUS_LOAD, 64'h1230, 0, 1, 0, 0, 0);
    step();
    drive(BUS_NONE, 64'h1230, 64'h0, 4'd0, 4'd0, 64'h0);
    expect_out("idle", BUS_NONE, 0, 0, 0, 0, 0, 0);
    step();
    drive(BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd1, 64'hDEAD_BEEF);
    expect_out("fill1", BUS_NONE, 0, 0, 0, 0, 1, 64'hDEAD_BEEF);
    step();
    drive(BUS_LOAD, 64'h1234, 64'h0, 4'd5, 4'd0, 64'h0);
    expect_out("hit1", BUS_NONE, 0, 0, 0, 1, 0, 64'hDEAD_BEEF);
    step();

    // Store hit updates the line and writes through.
    drive(BUS_STORE, 64'h1230, 64'h55, 4'd2, 4'd0, 64'h0);
    expect_out("st_hit", BUS_STORE, 64'h1230, 64'h55, 2, 0, 0, 0);
    step();
    drive(BUS_LOAD, 64'h1237, 64'h0, 4'd0, 4'd0, 64'h0);
    expect_out("hit55", BUS_NONE, 0, 0, 0, 1, 0, 64'h55);
    step();

    // Miss to 0x2230 (same line index 6), then a store kills the pending fill.
    drive(BUS_LOAD, 64'h2230, 64'h0, 4'd3, 4'd0, 64'h0);
    expect_out("miss3", BUS_LOAD, 64'h2230, 0, 3, 0, 0, 0);
    step();
    drive(BUS_STORE, 64'h2230, 64'h77, 4'd4, 4'd0, 64'h0);
    expect_out("st_miss", BUS_STORE, 64'h2230, 64'h77, 4, 0, 0, 0);
    step();
    drive(BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd3, 64'h99);
    expect_out("stale_fill", BUS_NONE, 0, 0, 0, 0, 3, 64'h99);
    step();
    drive(BUS_LOAD, 64'h2230, 64'h0, 4'd0, 4'd0, 64'h0);
    expect_out("after_stale", BUS_LOAD, 64'h2230, 0, 0, 0, 0, 0);
    step();
    drive(BUS_LOAD, 64'h1230, 64'h0, 4'd0, 4'd0, 64'h0);
    expect_out("line_kept", BUS_NONE, 0, 0, 0, 1, 0, 64'h55);
    step();

    // No write-allocate on a store miss.
    drive(BUS_STORE, 64'h5008, 64'h1234, 4'd6, 4'd0, 64'h0);
    expect_out("st_noalloc", BUS_STORE, 64'h5008, 64'h1234, 6, 0, 0, 0);
    step();
    drive(BUS_LOAD, 64'h5008, 64'h0, 4'd0, 4'd0, 64'h0);
    expect_out("noalloc_ld", BUS_LOAD, 64'h5008, 0, 0, 0, 0, 0);
    step();

    // Fill with unknown tag 7 plus a would-be hit: load goes to memory as tag 5.
    drive(BUS_LOAD, 64'h1230, 64'h0, 4'd5, 4'd7, 64'hAA);
    expect_out("fill_vs_hit", BUS_LOAD, 64'h1230, 0, 5, 0, 7, 64'hAA);
    step();
    // Fill tag 5 lands in line 6 while a new miss (line 7, tag 0x32) reuses tag 5.
    drive(BUS_LOAD, 64'h3238, 64'h0, 4'd5, 4'd5, 64'hBB);
    expect_out("reuse_tag", BUS_LOAD, 64'h3238, 0, 5, 0, 5, 64'hBB);
    step();
    drive(BUS_LOAD, 64'h1230, 64'h0, 4'd0, 4'd0, 64'h0);
    expect_out("hitBB", BUS_NONE, 0, 0, 0, 1, 0, 64'hBB);
    step();
    drive(BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd5, 64'hCC);
    expect_out("fill5b", BUS_NONE, 0, 0, 0, 0, 5, 64'hCC);
    step();
    drive(BUS_LOAD, 64'h3238, 64'h0, 4'd0, 4'd0, 64'h0);
    expect_out("hitCC", BUS_NONE, 0, 0, 0, 1, 0, 64'hCC);
    step();

    // Reset mid-operation clears the lines.
    reset = 1'b1;
    drive(BUS_LOAD, 64'h1230, 64'h0, 4'd1, 4'd0, 64'h0);
    expect_out("reset2", BUS_NONE, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    drive(BUS_LOAD, 64'h1230, 64'h0, 4'd1, 4'd0, 64'h0);
    expect_out("post_reset", BUS_LOAD, 64'h1230, 0, 1, 0, 0, 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
